// File: rtl/decode_block.sv
// Instruction decode stage: register file with write-back bypass, pending-write
// scoreboard, hazard stall, jump/branch resolution and halt handling.
module decode_block (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  input  logic        flag_we,
  input  logic [1:0]  flag_in,
  input  logic [15:0] io_data,
  input  logic [15:0] ret_addr,
  output logic [5:0]  op_dec,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [15:0] data_in,
  output logic [3:0]  dest_dec,
  output logic        wr_dec,
  output logic        dec_valid,
  output logic        pc_load,
  output logic [15:0] pc_target,
  output logic        halted,
  output logic        illegal_op
);

  // state   | meaning
  // RUN     | decoding, accepting instructions when operands are available
  // STALL   | current instruction waits on a pending source register
  // BR_WAIT | conditional jump waits for scoreboard to drain and flags to settle
  // HALT    | HLT seen; only reset leaves this state
  typedef enum logic [1:0] {RUN, STALL, BR_WAIT, HALT} state_t;

  state_t state, state_next;

  logic [15:0] rf [16];
  logic [15:0] pend, pend_next;
  logic [1:0]  flag;
  logic [1:0]  br_op;
  logic [15:0] br_imm;

  logic [5:0]  op;
  logic [3:0]  rd, rs, rt;
  logic [15:0] imm;

  assign op  = instr[31:26];
  assign rd  = instr[25:22];
  assign rs  = instr[21:18];
  assign rt  = instr[17:14];
  assign imm = instr[15:0];

  logic legal, reads_rs, reads_rt, writes, is_jmp, is_ret, is_cj, is_hlt;
  logic [1:0] di_sel;  // 0: zero, 1: imm, 2: io_data

  always_comb begin
    legal    = 1'b1;
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    writes   = 1'b0;
    is_jmp   = 1'b0;
    is_ret   = 1'b0;
    is_cj    = 1'b0;
    is_hlt   = 1'b0;
    di_sel   = 2'd0;
    case (op)
      6'h00, 6'h01, 6'h04, 6'h05, 6'h06: begin
        reads_rs = 1'b1; reads_rt = 1'b1; writes = 1'b1;
      end
      6'h02, 6'h07: begin reads_rt = 1'b1; writes = 1'b1; end
      6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e: begin
        reads_rs = 1'b1; writes = 1'b1; di_sel = 2'd1;
      end
      6'h0a, 6'h0f: begin writes = 1'b1; di_sel = 2'd1; end
      6'h10: is_ret = 1'b1;
      6'h11: is_hlt = 1'b1;
      6'h14: begin reads_rs = 1'b1; writes = 1'b1; end
      6'h15: begin reads_rs = 1'b1; reads_rt = 1'b1; end
      6'h16: begin writes = 1'b1; di_sel = 2'd2; end
      6'h17: reads_rs = 1'b1;
      6'h18: begin is_jmp = 1'b1; di_sel = 2'd1; end
      6'h19, 6'h1a, 6'h1b: begin
        reads_rs = 1'b1; reads_rt = 1'b1; writes = 1'b1;
      end
      6'h1c, 6'h1d, 6'h1e, 6'h1f: begin is_cj = 1'b1; di_sel = 2'd1; end
      default: legal = 1'b0;
    endcase
  end

  // A same-cycle write-back both forwards its data and unblocks a pending source.
  logic rs_byp, rt_byp, blocked;
  logic [15:0] a_rd, b_rd;

  assign rs_byp  = wb_en && (wb_addr == rs);
  assign rt_byp  = wb_en && (wb_addr == rt);
  assign a_rd    = rs_byp ? wb_data : rf[rs];
  assign b_rd    = rt_byp ? wb_data : rf[rt];
  assign blocked = (reads_rs && pend[rs] && !rs_byp) ||
                   (reads_rt && pend[rt] && !rt_byp);

  logic accept, br_leave, br_taken;

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN, STALL: begin
        if (accept) begin
          if (legal && is_hlt)     state_next = HALT;
          else if (legal && is_cj) state_next = BR_WAIT;
          else                     state_next = RUN;
        end else if (instr_valid && blocked) begin
          state_next = STALL;
        end else begin
          state_next = RUN;
        end
      end
      BR_WAIT: if (br_leave) state_next = RUN;
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    br_leave    = 1'b0;
    br_taken    = 1'b0;
    if (!reset && !pc_load && (state == RUN || state == STALL) && !blocked)
      instr_ready = 1'b1;
    if (state == BR_WAIT && pend == 16'h0000 && !flag_we)
      br_leave = 1'b1;
    case (br_op)
      2'd0: br_taken = flag[0];
      2'd1: br_taken = !flag[0];
      2'd2: br_taken = flag[1];
      default: br_taken = !flag[1];
    endcase
  end

  assign accept = instr_valid && instr_ready;

  // Set beats clear when an accepted writer and a write-back hit the same bit.
  always_comb begin
    pend_next = pend;
    if (wb_en) pend_next[wb_addr] = 1'b0;
    if (accept && legal && writes) pend_next[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
      pend       <= 16'h0000;
      flag       <= 2'b00;
      br_op      <= 2'b00;
      br_imm     <= 16'h0000;
      op_dec     <= 6'h00;
      A          <= 16'h0000;
      B          <= 16'h0000;
      data_in    <= 16'h0000;
      dest_dec   <= 4'h0;
      wr_dec     <= 1'b0;
      dec_valid  <= 1'b0;
      pc_load    <= 1'b0;
      pc_target  <= 16'h0000;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      if (wb_en)   rf[wb_addr] <= wb_data;
      if (flag_we) flag <= flag_in;
      pend       <= pend_next;
      dec_valid  <= 1'b0;
      pc_load    <= 1'b0;
      illegal_op <= 1'b0;
      if (accept) begin
        if (!legal) begin
          illegal_op <= 1'b1;
        end else if (is_jmp || is_ret) begin
          pc_load   <= 1'b1;
          pc_target <= is_ret ? ret_addr : imm;
        end else if (is_cj) begin
          br_op  <= op[1:0];
          br_imm <= imm;
        end else begin
          dec_valid <= 1'b1;
          op_dec    <= op;
          A         <= a_rd;
          B         <= b_rd;
          data_in   <= (di_sel == 2'd1) ? imm : (di_sel == 2'd2) ? io_data : 16'h0000;
          dest_dec  <= rd;
          wr_dec    <= writes;
          if (is_hlt) halted <= 1'b1;
        end
      end
      if (br_leave && br_taken) begin
        pc_load   <= 1'b1;
        pc_target <= br_imm;
      end
    end
  end

endmodule

// File: tb/tb_decode_block.sv
// Directed bench for decode_block: operand fetch, hazards, jumps, halt, reset.
module tb_decode_block;

  logic        clk = 1'b0;
  logic        reset, instr_valid, instr_ready, wb_en, flag_we;
  logic [31:0] instr;
  logic [3:0]  wb_addr, dest_dec;
  logic [15:0] wb_data, io_data, ret_addr, A, B, data_in, pc_target;
  logic [1:0]  flag_in;
  logic [5:0]  op_dec;
  logic        wr_dec, dec_valid, pc_load, halted, illegal_op;

  int n_chk = 0;
  int n_pass = 0;

  decode_block dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_we(flag_we), .flag_in(flag_in), .io_data(io_data), .ret_addr(ret_addr),
    .op_dec(op_dec), .A(A), .B(B), .data_in(data_in), .dest_dec(dest_dec),
    .wr_dec(wr_dec), .dec_valid(dec_valid), .pc_load(pc_load), .pc_target(pc_target),
    .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [3:0] rt);
    return {op, rd, rs, rt, 14'b0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs, input logic [15:0] imm);
    return {op, rd, rs, 2'b00, imm};
  endfunction

  initial begin
    reset = 1'b1; instr = 32'h0; instr_valid = 1'b0;
    wb_en = 1'b0; wb_addr = 4'h0; wb_data = 16'h0;
    flag_we = 1'b0; flag_in = 2'b00; io_data = 16'h0; ret_addr = 16'h0;

    tick(); tick();
    check("rst_ready", instr_ready, 0);
    check("rst_halted", halted, 0);
    check("rst_dec_valid", dec_valid, 0);
    reset = 1'b0; #1;
    check("run_ready", instr_ready, 1);

    // ADD with operands from write-back
    wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'd5; tick();
    wb_addr = 4'd2; wb_data = 16'd3; tick();
    wb_en = 1'b0;
    instr = mk_r(6'h00, 4'd3, 4'd1, 4'd2); instr_valid = 1'b1; #1;
    check("add_ready", instr_ready, 1);
    tick(); instr_valid = 1'b0;
    check("add_valid", dec_valid, 1);
    check("add_op", op_dec, 6'h00);
    check("add_A", A, 16'd5);
    check("add_B", B, 16'd3);
    check("add_wr", wr_dec, 1);
    check("add_dest", dest_dec, 4'd3);
    check("add_data_in", data_in, 16'h0);
    check("add_pend", dut.pend, 16'h0008);
    tick();
    check("add_pulse", dec_valid, 0);
    check("add_hold_A", A, 16'd5);

    // SUB stalls on pending R3 until its write-back arrives
    instr = mk_r(6'h01, 4'd4, 4'd3, 4'd1); instr_valid = 1'b1; #1;
    check("sub_blocked", instr_ready, 0);
    tick();
    check("sub_stall_state", 32'(dut.state), 1);
    check("sub_stall_ready", instr_ready, 0);
    tick();
    check("sub_no_valid", dec_valid, 0);
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'd8; #1;
    check("sub_bypass_ready", instr_ready, 1);
    tick(); wb_en = 1'b0; instr_valid = 1'b0;
    check("sub_valid", dec_valid, 1);
    check("sub_op", op_dec, 6'h01);
    check("sub_A", A, 16'd8);
    check("sub_B", B, 16'd5);
    check("sub_dest", dest_dec, 4'd4);
    check("sub_pend", dut.pend, 16'h0010);
    check("sub_run_state", 32'(dut.state), 0);

    // JV waits on pend[4], then taken after flag overflow set
    instr = mk_i(6'h1c, 4'd0, 4'd0, 16'h0123); instr_valid = 1'b1; #1;
    check("jv_ready", instr_ready, 1);
    tick(); instr_valid = 1'b0;
    check("jv_brwait", 32'(dut.state), 2);
    check("jv_ready_wait", instr_ready, 0);
    tick(); tick();
    check("jv_hold_pcl", pc_load, 0);
    check("jv_hold_state", 32'(dut.state), 2);
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h0044; flag_we = 1'b1; flag_in = 2'b01;
    tick(); wb_en = 1'b0; flag_we = 1'b0;
    check("jv_flagwe_pcl", pc_load, 0);
    check("jv_pend_clear", dut.pend, 16'h0000);
    check("jv_still_wait", 32'(dut.state), 2);
    tick();
    check("jv_pc_load", pc_load, 1);
    check("jv_target", pc_target, 16'h0123);
    check("jv_dec_valid", dec_valid, 0);
    check("jv_ready_pcl", instr_ready, 0);
    tick();
    check("jv_pcl_pulse", pc_load, 0);
    check("jv_ready_after", instr_ready, 1);

    // JZ taken / JNZ not taken with zero flag set
    flag_we = 1'b1; flag_in = 2'b10; tick(); flag_we = 1'b0;
    instr = mk_i(6'h1e, 4'd0, 4'd0, 16'h0040); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("jz_wait_pcl", pc_load, 0);
    tick();
    check("jz_pc_load", pc_load, 1);
    check("jz_target", pc_target, 16'h0040);
    tick();
    instr = mk_i(6'h1f, 4'd0, 4'd0, 16'h0080); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    tick();
    check("jnz_no_pcl", pc_load, 0);
    check("jnz_target_hold", pc_target, 16'h0040);
    check("jnz_run", 32'(dut.state), 0);
    check("jnz_ready", instr_ready, 1);

    // JMP and RET
    instr = mk_i(6'h18, 4'd0, 4'd0, 16'h1234); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("jmp_pcl", pc_load, 1);
    check("jmp_target", pc_target, 16'h1234);
    check("jmp_ready", instr_ready, 0);
    check("jmp_dec_valid", dec_valid, 0);
    tick();
    ret_addr = 16'h0bad;
    instr = mk_i(6'h10, 4'd0, 4'd0, 16'h0000); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("ret_pcl", pc_load, 1);
    check("ret_target", pc_target, 16'h0bad);
    tick();

    // Illegal opcode, IN, ADI, ST
    instr = {6'b000011, 26'h0}; instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("ill_pulse", illegal_op, 1);
    check("ill_dec_valid", dec_valid, 0);
    check("ill_pend", dut.pend, 16'h0000);
    tick();
    check("ill_pulse_end", illegal_op, 0);
    io_data = 16'hbeef;
    instr = mk_r(6'h16, 4'd5, 4'd0, 4'd0); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("in_valid", dec_valid, 1);
    check("in_data", data_in, 16'hbeef);
    check("in_wr", wr_dec, 1);
    check("in_dest", dest_dec, 4'd5);
    instr = mk_i(6'h08, 4'd6, 4'd1, 16'h0007); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("adi_data", data_in, 16'h0007);
    check("adi_A", A, 16'd5);
    check("adi_dest", dest_dec, 4'd6);
    instr = mk_r(6'h15, 4'd0, 4'd2, 4'd1); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check("st_valid", dec_valid, 1);
    check("st_wr", wr_dec, 0);
    check("st_A", A, 16'd3);
    check("st_B", B, 16'd5);
    check("st_data", data_in, 16'h0);

    // Same-cycle bypass on both operands, then set-wins on scoreboard
    wb_en = 1'b1; wb_addr = 4'd7; wb_data = 16'h0077;
    instr = mk_r(6'h00, 4'd8, 4'd7, 4'd7); instr_valid = 1'b1; #1;
    check("byp_ready", instr_ready, 1);
    tick(); wb_en = 1'b0; instr_valid = 1'b0;
    check("byp_A", A, 16'h0077);
    check("byp_B", B, 16'h0077);
    wb_en = 1'b1; wb_addr = 4'd9; wb_data = 16'h0099;
    instr = mk_r(6'h00, 4'd9, 4'd1, 4'd2); instr_valid = 1'b1;
    tick(); wb_en = 1'b0; instr_valid = 1'b0;
    check("set_wins_pend", dut.pend, 16'h0360);
    instr = mk_r(6'h02, 4'd10, 4'd0, 4'd5); instr_valid = 1'b1; #1;
    check("mov_rt_blocked", instr_ready, 0);
    instr_valid = 1'b0;
    tick();

    // HLT, activity during halt, then reset
    instr = mk_r(6'h11, 4'd0, 4'd0, 4'd0); instr_valid = 1'b1; #1;
    check("hlt_ready", instr_ready, 1);
    tick();
    instr = 32'h0;
    check("hlt_halted", halted, 1);
    check("hlt_state", 32'(dut.state), 3);
    for (int i = 0; i < 20; i++) begin
      wb_en = (i == 5); wb_addr = 4'd10; wb_data = 16'h00aa;
      flag_we = (i == 7); flag_in = 2'b01;
      #1;
      check("halt_ready", instr_ready, 0);
      check("halt_flag", halted, 1);
      tick();
    end
    wb_en = 1'b0; flag_we = 1'b0; instr_valid = 1'b0;
    check("halt_wb", dut.rf[10], 16'h00aa);
    check("halt_flag_we", dut.flag, 2'b01);
    reset = 1'b1; wb_en = 1'b1; wb_addr = 4'd11; wb_data = 16'h00bb;
    tick();
    reset = 1'b0; wb_en = 1'b0; #1;
    check("post_rst_halted", halted, 0);
    check("post_rst_state", 32'(dut.state), 0);
    check("post_rst_ready", instr_ready, 1);
    check("post_rst_pend", dut.pend, 16'h0000);
    check("post_rst_flag", dut.flag, 2'b00);
    for (int i = 0; i < 16; i++) check("post_rst_rf", dut.rf[i], 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
